cpu_regfile_p: RTL and testbench

- Parametrised general-purpose register file and flags register for the 8-bit CPU datapath.
- Generalises the fixed four-register ax/bx/cx/dx bank to DATA_W-wide data and 2**ADDR_W registers.
- Adds the following over the fixed bank:
  - latched read addresses with an address-lock hold;
  - optional write-to-read bypass;
  - optional hard-wired zero register;
  - bit-masked flags update;
  - flattened debug bus of all registers.
- Sits between the instruction decoder (aa/ab/ad, WR, addr_lock) and the ALU/memory path.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_flagreg.sv | 36 +++
 rtl/cpu_regfile_p.sv | 133 +++++++++++++
 tb/tb_cpu_regfile_p.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU datapath.
//   - Default data and register-address widths for the register file.
//   - Bit positions of the status flags in the flags register.
//   - Symbolic indices of the classic four general-purpose registers.
// No ports: this is a package imported with "import cpu_pkg::*;".
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Default datapath width and register address width (2**2 = 4 registers)
  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 2;

  // Status flag bit positions inside the flags register
  localparam int FLG_Z = 0;  // zero
  localparam int FLG_C = 1;  // carry
  localparam int FLG_N = 2;  // negative
  localparam int FLG_V = 3;  // overflow

  // Register indices of the fixed ax/bx/cx/dx bank
  typedef enum logic [1:0] {
    REG_AX = 2'd0,
    REG_BX = 2'd1,
    REG_CX = 2'd2,
    REG_DX = 2'd3
  } reg_idx_e;

endpackage : cpu_pkg

// File: rtl/cpu_flagreg.sv
// ---------------------------------------------------------------------------
// cpu_flagreg
// Bit-masked flags register. Only bits selected by flag_we take the value
// from flag_in; all other bits keep their stored value. Also used by the
// ALU status path, so it is kept as a standalone block.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous active-high reset, clears all flags
//   flag_we  in   [W-1:0] per-bit update mask
//   flag_in  in   [W-1:0] new flag values
//   flags    out  [W-1:0] registered flags
// ---------------------------------------------------------------------------
module cpu_flagreg
  import cpu_pkg::*;
#(
  parameter int W = CPU_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] flag_we,
  input  logic [W-1:0] flag_in,
  output logic [W-1:0] flags
);

  // Masked merge: selected bits take flag_in, the rest hold.
  // Reset has priority over any update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~flag_we) | (flag_in & flag_we);
    end
  end

endmodule : cpu_flagreg

// File: rtl/cpu_regfile_p.sv
// ---------------------------------------------------------------------------
// cpu_regfile_p
// Parametrised general-purpose register file plus flags register for the
// CPU datapath. Read addresses are latched (and can be frozen with
// addr_lock), so read data appears one cycle after the address is presented.
// An optional bypass forwards a same-cycle write to a matching read port,
// and an optional hard-wired zero register makes register 0 read as 0.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous active-high reset
//   ra_addr    in   [ADDR_W-1:0] read port A address (aa)
//   rb_addr    in   [ADDR_W-1:0] read port B address (ab)
//   rd_addr    in   [ADDR_W-1:0] write address (ad)
//   wr_en      in   write enable (WR)
//   wr_data    in   [DATA_W-1:0] write data
//   addr_lock  in   1 = hold the latched read addresses
//   flag_we    in   [DATA_W-1:0] per-bit flag update mask
//   flag_in    in   [DATA_W-1:0] new flag values
//   ra_data    out  [DATA_W-1:0] read port A data
//   rb_data    out  [DATA_W-1:0] read port B data
//   flags      out  [DATA_W-1:0] flags register
//   dbg_regs   out  [REG_CNT*DATA_W-1:0] all registers, reg i at
//                   bits [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module cpu_regfile_p
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_W-1:0]                ra_addr,
  input  logic [ADDR_W-1:0]                rb_addr,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             wr_en,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             addr_lock,
  input  logic [DATA_W-1:0]                flag_we,
  input  logic [DATA_W-1:0]                flag_in,
  output logic [DATA_W-1:0]                ra_data,
  output logic [DATA_W-1:0]                rb_data,
  output logic [DATA_W-1:0]                flags,
  output logic [(2**ADDR_W)*DATA_W-1:0]    dbg_regs
);

  localparam int REG_CNT = 2**ADDR_W;
  localparam bit BYP_EN  = (BYPASS != 0);
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs     [REG_CNT];
  logic [DATA_W-1:0] reg_view [REG_CNT];
  logic [ADDR_W-1:0] ra_q;
  logic [ADDR_W-1:0] rb_q;
  logic              wr_to_zero;
  logic              wr_eff;
  logic              byp_ok;

  // A write to register 0 is meaningless when it is hard-wired to zero, so
  // such writes are dropped and never forwarded.
  assign wr_to_zero = ZERO_EN && (rd_addr == '0);
  assign wr_eff     = wr_en && !wr_to_zero;

  // Bypass is suppressed while reset is asserted since that write is discarded.
  assign byp_ok     = BYP_EN && wr_eff && !rst;

  // Latched read addresses; addr_lock freezes them so the decoder can hold
  // operands steady across multi-cycle operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q <= '0;
      rb_q <= '0;
    end else if (!addr_lock) begin
      ra_q <= ra_addr;
      rb_q <= rb_addr;
    end
  end

  // Register array: reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // Architectural view of the registers: register 0 is forced to zero when
  // hard-wired, so it reads 0 even before the first reset.
  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      reg_view[i] = (ZERO_EN && (i == 0)) ? '0 : regs[i];
    end
  end

  // Read ports: combinational from the latched address, with optional
  // forwarding of a write landing on the same register this cycle.
  always_comb begin
    ra_data = reg_view[ra_q];
    rb_data = reg_view[rb_q];
    if (byp_ok && (rd_addr == ra_q)) begin
      ra_data = wr_data;
    end
    if (byp_ok && (rd_addr == rb_q)) begin
      rb_data = wr_data;
    end
  end

  // Flattened debug bus of every register.
  always_comb begin
    dbg_regs = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      dbg_regs[i*DATA_W +: DATA_W] = reg_view[i];
    end
  end

  // Masked flags register.
  cpu_flagreg #(
    .W (DATA_W)
  ) u_flagreg (
    .clk     (clk),
    .rst     (rst),
    .flag_we (flag_we),
    .flag_in (flag_in),
    .flags   (flags)
  );

endmodule : cpu_regfile_p

// File: tb/tb_cpu_regfile_p.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile_p
// Directed testbench for cpu_regfile_p. Four instances share the clock and
// reset: a default one (bypass on), one without bypass, one with a
// hard-wired zero register (all three share 8-bit stimulus) and a 16-bit,
// 8-register one with its own stimulus.
// ---------------------------------------------------------------------------
module tb_cpu_regfile_p;

  logic clk = 1'b0;
  logic rst;

  // Shared 8-bit stimulus
  logic [1:0]  ra_addr, rb_addr, rd_addr;
  logic        wr_en, addr_lock;
  logic [7:0]  wr_data, flag_we, flag_in;

  // Default instance outputs
  logic [7:0]  a_ra, a_rb, a_flags;
  logic [31:0] a_dbg;
  // No-bypass instance outputs
  logic [7:0]  n_ra, n_rb, n_flags;
  logic [31:0] n_dbg;
  // Zero-register instance outputs
  logic [7:0]  z_ra, z_rb, z_flags;
  logic [31:0] z_dbg;

  // Wide instance stimulus and outputs
  logic [2:0]   w_ra_addr, w_rb_addr, w_rd_addr;
  logic         w_wr_en, w_lock;
  logic [15:0]  w_wr_data, w_flag_we, w_flag_in;
  logic [15:0]  w_ra, w_rb, w_flags;
  logic [127:0] w_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_regfile_p #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_data(wr_data), .addr_lock(addr_lock), .flag_we(flag_we),
    .flag_in(flag_in), .ra_data(a_ra), .rb_data(a_rb), .flags(a_flags), .dbg_regs(a_dbg)
  );

  cpu_regfile_p #(.DATA_W(8), .ADDR_W(2), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_data(wr_data), .addr_lock(addr_lock), .flag_we(flag_we),
    .flag_in(flag_in), .ra_data(n_ra), .rb_data(n_rb), .flags(n_flags), .dbg_regs(n_dbg)
  );

  cpu_regfile_p #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_data(wr_data), .addr_lock(addr_lock), .flag_we(flag_we),
    .flag_in(flag_in), .ra_data(z_ra), .rb_data(z_rb), .flags(z_flags), .dbg_regs(z_dbg)
  );

  cpu_regfile_p #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u_wide (
    .clk(clk), .rst(rst), .ra_addr(w_ra_addr), .rb_addr(w_rb_addr), .rd_addr(w_rd_addr),
    .wr_en(w_wr_en), .wr_data(w_wr_data), .addr_lock(w_lock), .flag_we(w_flag_we),
    .flag_in(w_flag_in), .ra_data(w_ra), .rb_data(w_rb), .flags(w_flags), .dbg_regs(w_dbg)
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); wr_data = 8'h55; wr_en = 1'b1;
      cyc();
    end
    wr_en = 1'b0;
    flag_we = 8'hFF; flag_in = 8'hAA;
    cyc();
    flag_we = 8'h00;
    #1;
    total++; if (a_dbg !== 32'h55555555) begin bad++; $display("[TB] FAIL pre_reset_dbg got=%h exp=%h", a_dbg, 32'h55555555); end
    total++; if (a_flags !== 8'hAA) begin bad++; $display("[TB] FAIL pre_reset_flags got=%h exp=%h", a_flags, 8'hAA); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (a_dbg[i*8 +: 8] !== 8'h00) begin bad++; $display("[TB] FAIL reset_dbg%0d got=%h exp=%h", i, a_dbg[i*8 +: 8], 8'h00); end
    end
    total++; if (a_flags !== 8'h00) begin bad++; $display("[TB] FAIL reset_flags got=%h exp=%h", a_flags, 8'h00); end
    total++; if (a_ra !== 8'h00) begin bad++; $display("[TB] FAIL reset_ra got=%h exp=%h", a_ra, 8'h00); end
    total++; if (a_rb !== 8'h00) begin bad++; $display("[TB] FAIL reset_rb got=%h exp=%h", a_rb, 8'h00); end
  endtask

  task automatic test_bypass();
    ra_addr = 2'd2; rb_addr = 2'd2; wr_en = 1'b0;
    cyc();
    rd_addr = 2'd2; wr_data = 8'hA5; wr_en = 1'b1;
    #1;
    total++; if (a_ra !== 8'hA5) begin bad++; $display("[TB] FAIL byp_ra_same_cycle got=%h exp=%h", a_ra, 8'hA5); end
    total++; if (n_ra !== 8'h00) begin bad++; $display("[TB] FAIL nobyp_ra_same_cycle got=%h exp=%h", n_ra, 8'h00); end
    cyc();
    wr_en = 1'b0;
    #1;
    total++; if (n_ra !== 8'hA5) begin bad++; $display("[TB] FAIL nobyp_ra_next got=%h exp=%h", n_ra, 8'hA5); end
    total++; if (a_ra !== 8'hA5) begin bad++; $display("[TB] FAIL byp_ra_next got=%h exp=%h", a_ra, 8'hA5); end
    rd_addr = 2'd2; wr_data = 8'h5A; wr_en = 1'b1;
    #1;
    total++; if (a_rb !== 8'h5A) begin bad++; $display("[TB] FAIL byp_rb_same_cycle got=%h exp=%h", a_rb, 8'h5A); end
    total++; if (n_rb !== 8'hA5) begin bad++; $display("[TB] FAIL nobyp_rb_same_cycle got=%h exp=%h", n_rb, 8'hA5); end
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_addr_lock();
    rd_addr = 2'd1; wr_data = 8'h11; wr_en = 1'b1;
    cyc();
    rd_addr = 2'd3; wr_data = 8'h33;
    cyc();
    wr_en = 1'b0;
    ra_addr = 2'd1;
    cyc();
    total++; if (a_ra !== 8'h11) begin bad++; $display("[TB] FAIL lock_latch got=%h exp=%h", a_ra, 8'h11); end
    addr_lock = 1'b1; ra_addr = 2'd3; rb_addr = 2'd3;
    cyc();
    cyc();
    total++; if (a_ra !== 8'h11) begin bad++; $display("[TB] FAIL lock_hold_ra got=%h exp=%h", a_ra, 8'h11); end
    total++; if (a_rb !== 8'h5A) begin bad++; $display("[TB] FAIL lock_hold_rb got=%h exp=%h", a_rb, 8'h5A); end
    addr_lock = 1'b0;
    #1;
    total++; if (a_ra !== 8'h11) begin bad++; $display("[TB] FAIL unlock_same_cycle got=%h exp=%h", a_ra, 8'h11); end
    cyc();
    total++; if (a_ra !== 8'h33) begin bad++; $display("[TB] FAIL unlock_ra got=%h exp=%h", a_ra, 8'h33); end
    total++; if (a_rb !== 8'h33) begin bad++; $display("[TB] FAIL unlock_rb_same_reg got=%h exp=%h", a_rb, 8'h33); end
  endtask

  task automatic test_flags();
    flag_in = 8'hFF; flag_we = 8'h05;
    cyc();
    total++; if (a_flags !== 8'h05) begin bad++; $display("[TB] FAIL flags_set got=%h exp=%h", a_flags, 8'h05); end
    flag_in = 8'h00; flag_we = 8'h01;
    cyc();
    total++; if (a_flags !== 8'h04) begin bad++; $display("[TB] FAIL flags_clear got=%h exp=%h", a_flags, 8'h04); end
    flag_in = 8'hFF; flag_we = 8'h00;
    cyc();
    total++; if (a_flags !== 8'h04) begin bad++; $display("[TB] FAIL flags_hold got=%h exp=%h", a_flags, 8'h04); end
    // Flag update and register write in the same cycle
    flag_in = 8'hA0; flag_we = 8'hF0;
    rd_addr = 2'd0; wr_data = 8'h3C; wr_en = 1'b1;
    cyc();
    flag_we = 8'h00; wr_en = 1'b0;
    #1;
    total++; if (a_flags !== 8'hA4) begin bad++; $display("[TB] FAIL flags_with_write got=%h exp=%h", a_flags, 8'hA4); end
    total++; if (a_dbg[7:0] !== 8'h3C) begin bad++; $display("[TB] FAIL write_with_flags got=%h exp=%h", a_dbg[7:0], 8'h3C); end
    total++; if (z_dbg[7:0] !== 8'h00) begin bad++; $display("[TB] FAIL zero_r0_dropped got=%h exp=%h", z_dbg[7:0], 8'h00); end
  endtask

  task automatic test_zero_reg();
    ra_addr = 2'd0;
    cyc();
    rd_addr = 2'd0; wr_data = 8'hFF; wr_en = 1'b1;
    #1;
    total++; if (z_ra !== 8'h00) begin bad++; $display("[TB] FAIL zero_ra_write_cycle got=%h exp=%h", z_ra, 8'h00); end
    total++; if (a_ra !== 8'hFF) begin bad++; $display("[TB] FAIL r0_bypass got=%h exp=%h", a_ra, 8'hFF); end
    cyc();
    wr_en = 1'b0;
    #1;
    total++; if (z_ra !== 8'h00) begin bad++; $display("[TB] FAIL zero_ra_after got=%h exp=%h", z_ra, 8'h00); end
    total++; if (z_dbg[7:0] !== 8'h00) begin bad++; $display("[TB] FAIL zero_dbg0 got=%h exp=%h", z_dbg[7:0], 8'h00); end
    total++; if (z_dbg[31:8] !== 24'h335A11) begin bad++; $display("[TB] FAIL zero_other_regs got=%h exp=%h", z_dbg[31:8], 24'h335A11); end
    total++; if (a_dbg[7:0] !== 8'hFF) begin bad++; $display("[TB] FAIL r0_written got=%h exp=%h", a_dbg[7:0], 8'hFF); end
  endtask

  task automatic test_reset_during_write();
    rst = 1'b1;
    rd_addr = 2'd1; wr_data = 8'h77; wr_en = 1'b1;
    flag_we = 8'hFF; flag_in = 8'hFF;
    cyc();
    rst = 1'b0; wr_en = 1'b0; flag_we = 8'h00;
    #1;
    total++; if (a_dbg[15:8] !== 8'h00) begin bad++; $display("[TB] FAIL rst_wr_r1 got=%h exp=%h", a_dbg[15:8], 8'h00); end
    total++; if (a_dbg !== 32'h0) begin bad++; $display("[TB] FAIL rst_wr_all got=%h exp=%h", a_dbg, 32'h0); end
    total++; if (a_flags !== 8'h00) begin bad++; $display("[TB] FAIL rst_wr_flags got=%h exp=%h", a_flags, 8'h00); end
  endtask

  task automatic test_wide();
    logic [15:0] exp_reg;
    w_rd_addr = 3'd6; w_wr_data = 16'h1234; w_wr_en = 1'b1; w_rb_addr = 3'd7;
    cyc();
    w_rd_addr = 3'd7; w_wr_data = 16'hBEEF;
    cyc();
    w_wr_en = 1'b0;
    #1;
    total++; if (w_rb !== 16'hBEEF) begin bad++; $display("[TB] FAIL wide_rb got=%h exp=%h", w_rb, 16'hBEEF); end
    for (int i = 0; i < 8; i++) begin
      exp_reg = (i == 7) ? 16'hBEEF : (i == 6) ? 16'h1234 : 16'h0000;
      total++; if (w_dbg[i*16 +: 16] !== exp_reg) begin bad++; $display("[TB] FAIL wide_dbg%0d got=%h exp=%h", i, w_dbg[i*16 +: 16], exp_reg); end
    end
  endtask

  initial begin
    rst = 1'b1;
    ra_addr = '0; rb_addr = '0; rd_addr = '0; wr_en = 1'b0; wr_data = '0;
    addr_lock = 1'b0; flag_we = '0; flag_in = '0;
    w_ra_addr = '0; w_rb_addr = '0; w_rd_addr = '0; w_wr_en = 1'b0; w_wr_data = '0;
    w_lock = 1'b0; w_flag_we = '0; w_flag_in = '0;
    cyc();
    cyc();
    rst = 1'b0;
    test_reset();
    test_bypass();
    test_addr_lock();
    test_flags();
    test_zero_reg();
    test_reset_during_write();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_regfile_p
